// File: rtl/fir_out_decimator_if.sv
// fir_out_decimator_if: valid/ready output stream of the FIR decimator
//   m_data  : head-of-FIFO sample
//   m_valid : m_data is valid
//   m_ready : consumer accepts m_data this cycle
interface fir_out_decimator_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    modport master (output m_data, m_valid, input m_ready);
    modport slave  (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: decimate, round, scale and saturate FIR samples into a FWFT FIFO
//   clk, rst : clock and synchronous active-high reset
//   en       : y_in is valid this cycle
//   y_in     : unsigned FIR sample
//   m        : output stream (m_data, m_valid, m_ready)
//   count    : FIFO occupancy, 0..DEPTH
//   overflow : sticky, set when a kept sample is dropped
//   clr_ovf  : clears overflow; a same-cycle drop wins
module fir_out_decimator #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [IN_W-1:0]          y_in,
    fir_out_decimator_if.master      m,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;

    logic [PW-1:0]    phase;
    logic [IN_W:0]    r;
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] kept_q;
    logic             kept_v;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             pop, full, push, drop;

    // One extra bit so the rounding add cannot wrap at full scale
    if (SHIFT == 0) begin : g_ns
        assign r = {1'b0, y_in};
    end else begin : g_sh
        assign r = ({1'b0, y_in} + ((IN_W+1)'(1) << (SHIFT-1))) >> SHIFT;
    end

    assign s        = (r > (IN_W+1)'({OUT_W{1'b1}})) ? '1 : r[OUT_W-1:0];
    assign full     = count == CW'(DEPTH);
    assign pop      = m.m_valid && m.m_ready;
    // A pop frees the slot, so a full FIFO still accepts a write that cycle
    assign push     = kept_v && (!full || pop);
    assign drop     = kept_v && full && !pop;
    assign m.m_valid = count != '0;
    assign m.m_data  = m.m_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            kept_v   <= 1'b0;
            kept_q   <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (en)
                phase <= (phase == PW'(DECIM-1)) ? '0 : phase + 1'b1;
            kept_v <= en && phase == '0;
            kept_q <= s;
            if (push) begin
                mem[wp] <= kept_q;
                wp      <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: vector tables, corner sequences and random stimulus vs a queue model
module tb_fir_out_decimator;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst, en, clr_ovf;
    logic [15:0] y;
    logic [2:0]  cnt_a, cnt_b;
    logic        ovf_a, ovf_b;
    int          checks = 0;
    int          errors = 0;

    fir_out_decimator_if #(.OUT_W(8)) ia ();
    fir_out_decimator_if #(.OUT_W(8)) ib ();

    fir_out_decimator #(.DECIM(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .y_in(y), .m(ia.master),
        .count(cnt_a), .overflow(ovf_a), .clr_ovf(clr_ovf));
    fir_out_decimator #(.DECIM(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .y_in(y), .m(ib.master),
        .count(cnt_b), .overflow(ovf_b), .clr_ovf(clr_ovf));

    always #5 clk = ~clk;

    // Reference state: index 0 models DECIM=2, index 1 models DECIM=1
    int ph [2];
    bit pv [2];
    int pval [2];
    bit ov [2];
    int q [2][$];

    function automatic int sc(input int v);
        int rr;
        rr = (v + (1 << (SHIFT-1))) >> SHIFT;
        return rr > 255 ? 255 : rr;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input int yy, input bit rd, input bit c);
        bit p, dr;
        rst = r; en = e; y = yy[15:0]; clr_ovf = c;
        ia.m_ready = rd; ib.m_ready = rd;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                ph[d] = 0; pv[d] = 0; ov[d] = 0; q[d].delete();
            end else begin
                p  = q[d].size() > 0 && rd;
                dr = pv[d] && q[d].size() == DEPTH && !p;
                if (p) void'(q[d].pop_front());
                if (pv[d] && !dr) q[d].push_back(pval[d]);
                if (dr) ov[d] = 1; else if (c) ov[d] = 0;
                pv[d]   = e && ph[d] == 0;
                pval[d] = sc(yy);
                if (e) ph[d] = (ph[d] + 1) % (d == 0 ? 2 : 1);
            end
        end
        @(posedge clk); #1;
        chk("a_valid", ia.m_valid, q[0].size() > 0);
        chk("a_data",  ia.m_data,  q[0].size() > 0 ? q[0][0] : 0);
        chk("a_count", cnt_a, q[0].size());
        chk("a_ovf",   ovf_a, ov[0]);
        chk("b_valid", ib.m_valid, q[1].size() > 0);
        chk("b_data",  ib.m_data,  q[1].size() > 0 ? q[1][0] : 0);
        chk("b_count", cnt_b, q[1].size());
        chk("b_ovf",   ovf_b, ov[1]);
    endtask

    typedef struct { bit en; int y; bit rdy; bit ev; int ed; } vec_t;
    typedef struct { int y; int exp; } sat_t;

    initial begin
        vec_t tv [7];
        sat_t ts [5];
        tv[0] = '{1, 8,   1, 0, 0};
        tv[1] = '{1, 100, 1, 1, 1};
        tv[2] = '{1, 24,  1, 0, 0};
        tv[3] = '{1, 200, 1, 1, 2};
        tv[4] = '{1, 7,   1, 0, 0};
        tv[5] = '{0, 0,   1, 1, 0};
        tv[6] = '{0, 0,   1, 0, 0};
        ts[0] = '{16'h0FF7, 255};
        ts[1] = '{16'h0FF8, 255};
        ts[2] = '{16'h1000, 255};
        ts[3] = '{16'hFFFF, 255};
        ts[4] = '{16'h0FE7, 254};

        // Reset held with active inputs
        cycle(1, 1, 16'hFFFF, 0, 0);
        cycle(1, 1, 16'hFFFF, 0, 0);
        chk("rst_valid", ia.m_valid, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_data", ia.m_data, 0);

        // Decimation and rounding
        foreach (tv[i]) begin
            cycle(0, tv[i].en, tv[i].y, tv[i].rdy, 0);
            chk("dec_valid", ia.m_valid, tv[i].ev);
            chk("dec_data", ia.m_data, tv[i].ed);
        end

        // Saturation on the DECIM=1 instance, one-per-cycle flow
        foreach (ts[i]) begin
            cycle(0, 1, ts[i].y, 1, 0);
            if (i > 0) chk("sat_data", ib.m_data, ts[i-1].exp);
        end
        cycle(0, 0, 0, 1, 0);
        chk("sat_last", ib.m_data, ts[4].exp);

        // Backpressure and overflow
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 16 * (i + 1), 0, 0);
            cycle(0, 1, 12345, 0, 0);
            chk("bp_hold", ia.m_data, 1);
        end
        cycle(0, 0, 0, 0, 0);
        chk("bp_count", cnt_a, 4);
        chk("bp_ovf", ovf_a, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", ia.m_data, i + 1);
            cycle(0, 0, 0, 1, 0);
        end
        chk("bp_empty", cnt_a, 0);
        chk("bp_ovf_sticky", ovf_a, 1);

        // Clear without a drop
        cycle(0, 0, 0, 0, 1);
        chk("clr_ovf", ovf_a, 0);

        // Clear coinciding with a drop
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 16 * (i + 1), 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        cycle(0, 1, 80, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("clr_drop_ovf", ovf_a, 1);
        chk("clr_drop_cnt", cnt_a, 4);

        // Full FIFO with simultaneous pop and write
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 16 * (i + 1), 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        cycle(0, 1, 112, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("fp_count", cnt_a, 4);
        chk("fp_ovf", ovf_a, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fp_drain", ia.m_data, i < 3 ? i + 2 : 7);
            cycle(0, 0, 0, 1, 0);
        end

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 16 * (i + 1), 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0);
        chk("mr_pre", cnt_a, 3);
        cycle(1, 1, 16'hFFFF, 0, 0);
        chk("mr_count", cnt_a, 0);
        chk("mr_valid", ia.m_valid, 0);
        cycle(0, 1, 160, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("mr_first", ia.m_data, 10);
        chk("mr_cnt1", cnt_a, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) ? $urandom_range(0, 5000) : $urandom_range(0, 65535),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
